// File: rtl/riscv_cache_line_fill.sv
// Cache line-fill engine: one BIU burst per miss, beats assembled into a full cache line.
// Define RISCV_CACHE_FILL_CRITWORD_EN for critical-word-first wrapping bursts.
module riscv_cache_line_fill #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PLEN       = XLEN,
  parameter int unsigned BLOCK_SIZE = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    fill_req_i,
  input  logic [PLEN-1:0]         fill_adr_i,
  output logic                    fill_busy_o,
  output logic                    filling_o,
  output logic                    biu_stb_o,
  input  logic                    biu_stb_ack_i,
  output logic [PLEN-1:0]         biu_adr_o,
  output logic                    biu_wrap_o,
  input  logic [XLEN-1:0]         biu_d_i,
  input  logic                    biu_d_ack_i,
  input  logic                    biu_err_i,
  output logic [BLOCK_SIZE*8-1:0] line_o,
  output logic                    line_ack_o,
  output logic                    line_err_o,
  output logic [XLEN-1:0]         crit_word_o,
  output logic                    crit_word_valid_o
);

  localparam int unsigned BLK_BITS  = BLOCK_SIZE * 8;
  localparam int unsigned BEATS     = BLK_BITS / XLEN;
  localparam int unsigned BEAT_BITS = $clog2(BEATS);
  localparam int unsigned OFF_BITS  = $clog2(BLOCK_SIZE);
  localparam int unsigned BYTE_BITS = $clog2(XLEN / 8);

  typedef enum logic [2:0] {IDLE, REQ, DATA, DONE, ERR} state_e;

  state_e                state_q, state_d;
  logic [BEAT_BITS-1:0]  idx_q, idx_d;
  logic [BEAT_BITS-1:0]  cnt_q, cnt_d;
  logic [PLEN-1:0]       adr_q, adr_d;
  logic [BLK_BITS-1:0]   line_q, line_d;
  logic                  busy_q, busy_d;
  logic                  filling_q, filling_d;
  logic                  stb_q, stb_d;
  logic                  wrap_q, wrap_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [BEAT_BITS-1:0]  start_word_c;
  logic                  wrap_en_c;
  logic                  adr_unused;

`ifdef RISCV_CACHE_FILL_CRITWORD_EN
  assign start_word_c = fill_adr_i[OFF_BITS-1:BYTE_BITS];
  assign wrap_en_c    = 1'b1;
  assign adr_unused   = ^fill_adr_i[BYTE_BITS-1:0];
`else
  assign start_word_c = '0;
  assign wrap_en_c    = 1'b0;
  assign adr_unused   = ^fill_adr_i[OFF_BITS-1:0];
`endif

  // Next-state, beat assembly and registered-output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (fill_req_i) begin
          state_d = REQ;
          idx_d   = start_word_c;
          cnt_d   = '0;
          adr_d   = {fill_adr_i[PLEN-1:OFF_BITS], start_word_c, BYTE_BITS'(0)};
        end
      end
      REQ: begin
        if (biu_stb_ack_i) state_d = DATA;
      end
      DATA: begin
        // A bus error wins over any beat presented in the same cycle.
        if (biu_err_i) begin
          state_d = ERR;
        end else if (biu_d_ack_i) begin
          for (int unsigned w = 0; w < BEATS; w++) begin
            if (idx_q == BEAT_BITS'(w)) line_d[w*XLEN +: XLEN] = biu_d_i;
          end
          idx_d = idx_q + BEAT_BITS'(1);
          cnt_d = cnt_q + BEAT_BITS'(1);
          if (cnt_q == BEAT_BITS'(BEATS - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    filling_d = (state_d == REQ) || (state_d == DATA) || (state_d == DONE);
    stb_d     = (state_d == REQ);
    wrap_d    = wrap_en_c && (state_d == REQ);
    ack_d     = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      adr_q     <= '0;
      line_q    <= '0;
      busy_q    <= 1'b0;
      filling_q <= 1'b0;
      stb_q     <= 1'b0;
      wrap_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      filling_q <= filling_d;
      stb_q     <= stb_d;
      wrap_q    <= wrap_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign fill_busy_o = busy_q;
  assign filling_o   = filling_q;
  assign biu_stb_o   = stb_q;
  assign biu_adr_o   = adr_q;
  assign biu_wrap_o  = wrap_q;
  assign line_o      = line_q;
  assign line_ack_o  = ack_q;
  assign line_err_o  = err_q;

`ifdef RISCV_CACHE_FILL_CRITWORD_EN
  logic            first_q, first_d;
  logic [XLEN-1:0] crit_q, crit_d;
  logic            crit_vld_q, crit_vld_d;

  // Capture the first good beat of each fill; the pulse lines up with its line_o write
  always_comb begin
    first_d    = first_q;
    crit_d     = crit_q;
    crit_vld_d = 1'b0;
    if (state_q == IDLE && fill_req_i) begin
      first_d = 1'b1;
    end else if (state_q == DATA && !biu_err_i && biu_d_ack_i && first_q) begin
      first_d    = 1'b0;
      crit_d     = biu_d_i;
      crit_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_q    <= 1'b0;
      crit_q     <= '0;
      crit_vld_q <= 1'b0;
    end else begin
      first_q    <= first_d;
      crit_q     <= crit_d;
      crit_vld_q <= crit_vld_d;
    end
  end

  assign crit_word_o       = crit_q;
  assign crit_word_valid_o = crit_vld_q;
`else
  assign crit_word_o       = '0;
  assign crit_word_valid_o = 1'b0;
`endif

endmodule
